// File: rtl/text_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer_if
//  Description : Character write handshake and pixel-stage read port of the
//                text buffer.
//  Revision    : 1.0  initial release
// ============================================================================
interface text_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic [3:0] char_row;
  logic [5:0] char_col;
  logic [7:0] character_id;

  modport master (
    output wr_valid, wr_char, char_row, char_col,
    input  wr_ready, character_id
  );

  modport slave (
    input  wr_valid, wr_char, char_row, char_col,
    output wr_ready, character_id
  );
endinterface
`default_nettype wire

// File: rtl/text_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer
//  Description : Character-cell text buffer with a write cursor, control-code
//                handling and clearing. Optional blinking cursor overlay is
//                enabled by defining TEXT_BUFFER_CURSOR_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module text_buffer #(
  parameter int         ROW_NUMBER   = 15,
  parameter int         COL_NUMBER   = 40,
  parameter logic [7:0] BLANK_ID     = 8'h00,
  parameter int         BLINK_CYCLES = 25_000_000,
  parameter logic [7:0] CURSOR_ID    = 8'h7F
) (
  input  wire logic    clk,
  input  wire logic    reset,
  text_buffer_if.slave bus,
  output logic [3:0]   cursor_row,
  output logic [5:0]   cursor_col,
  output logic         busy
);
  localparam int                CELLS      = ROW_NUMBER * COL_NUMBER;
  localparam int                ADDR_W     = $clog2(CELLS);
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL_A = ADDR_W'(COL_NUMBER - 1);
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COL_NUMBER);
  localparam logic [3:0]        LAST_ROW   = 4'(ROW_NUMBER - 1);
  localparam logic [5:0]        LAST_COL   = 6'(COL_NUMBER - 1);
  localparam logic [7:0]        CH_BS      = 8'h08;
  localparam logic [7:0]        CH_NL      = 8'h0A;
  localparam logic [7:0]        CH_FF      = 8'h0C;

  if (ROW_NUMBER > 16 || COL_NUMBER > 64 || BLINK_CYCLES < 1 || CURSOR_ID == BLANK_ID) begin : g_bad_params
    $error("text_buffer: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [3:0]        row_q, row_d;
  logic [5:0]        col_q, col_d;
  logic              wr_ready_q, busy_q;
  logic [7:0]        character_id_q, character_id_d;
  logic [7:0]        mem_q [CELLS];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] row_base, cursor_addr, rd_addr;
  logic              rd_oob, show_cursor, transfer;

  assign row_base    = ADDR_W'(row_q) * COLS_A;
  assign cursor_addr = row_base + ADDR_W'(col_q);
  assign rd_addr     = ADDR_W'(bus.char_row) * COLS_A + ADDR_W'(bus.char_col);
  assign rd_oob      = (bus.char_row > LAST_ROW) || (bus.char_col > LAST_COL);
  assign transfer    = bus.wr_valid && wr_ready_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = BLANK_ID;
    case (state_q)
      CLR_ALL: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        if (clr_cnt_q == LAST_CELL) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
          row_d     = '0;
          col_d     = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      CLR_ROW: begin
        mem_we    = 1'b1;
        mem_waddr = row_base + clr_cnt_q;
        if (clr_cnt_q == LAST_COL_A) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (transfer) begin
          case (bus.wr_char)
            CH_NL: begin
              col_d = '0;
              if (row_q == LAST_ROW) begin
                row_d     = '0;
                state_d   = CLR_ROW;
                clr_cnt_d = '0;
              end else begin
                row_d = row_q + 4'd1;
              end
            end
            CH_BS: begin
              // Stepping back one cell is always linear address - 1, also across rows.
              if ((row_q != '0) || (col_q != '0)) begin
                mem_we    = 1'b1;
                mem_waddr = cursor_addr - ADDR_W'(1);
                if (col_q != '0) begin
                  col_d = col_q - 6'd1;
                end else begin
                  row_d = row_q - 4'd1;
                  col_d = LAST_COL;
                end
              end
            end
            CH_FF: begin
              state_d   = CLR_ALL;
              clr_cnt_d = '0;
            end
            default: begin
              mem_we    = 1'b1;
              mem_waddr = cursor_addr;
              mem_wdata = bus.wr_char;
              if (col_q == LAST_COL) begin
                col_d = '0;
                if (row_q == LAST_ROW) begin
                  row_d     = '0;
                  state_d   = CLR_ROW;
                  clr_cnt_d = '0;
                end else begin
                  row_d = row_q + 4'd1;
                end
              end else begin
                col_d = col_q + 6'd1;
              end
            end
          endcase
        end
      end
      default: begin
        state_d   = CLR_ALL;
        clr_cnt_d = '0;
      end
    endcase
  end

`ifdef TEXT_BUFFER_CURSOR_EN
  localparam int                 BLINK_W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign show_cursor = blink_q && (bus.char_row == row_q) && (bus.char_col == col_q);
`else
  assign show_cursor = 1'b0;
`endif

  always_comb begin
    character_id_d = mem_q[rd_addr];
    if (rd_oob) begin
      character_id_d = BLANK_ID;
    end else if (show_cursor) begin
      character_id_d = CURSOR_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= CLR_ALL;
      clr_cnt_q      <= '0;
      row_q          <= '0;
      col_q          <= '0;
      wr_ready_q     <= 1'b0;
      busy_q         <= 1'b1;
      character_id_q <= BLANK_ID;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      row_q          <= row_d;
      col_q          <= col_d;
      wr_ready_q     <= (state_d == IDLE);
      busy_q         <= (state_d != IDLE);
      character_id_q <= character_id_d;
    end
  end

  // Cell storage carries no reset; CLR_ALL after reset initialises it.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.wr_ready     = wr_ready_q;
  assign bus.character_id = character_id_q;
  assign cursor_row       = row_q;
  assign cursor_col       = col_q;
  assign busy             = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_text_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_buffer
//  Description : Directed scoreboard bench for text_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_text_buffer;
  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic       busy;

  always #5 clk = ~clk;

  text_buffer_if bus();

  text_buffer #(.BLINK_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  typedef struct {
    logic [3:0] r;
    logic [5:0] c;
    logic [7:0] exp;
  } rd_t;

  rd_t  sb[$];
  rd_t  mon_e;
  logic rd_issue   = 1'b0;
  logic rd_valid_q = 1'b0;
  int   errors     = 0;
  int   checks     = 0;
  int   cyc        = 0;

  always @(posedge clk) begin
    rd_valid_q <= rd_issue;
    cyc        <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rd_valid_q) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected got=%02h want=<none>", bus.character_id);
      end else begin
        mon_e = sb.pop_front();
        if (bus.character_id !== mon_e.exp) begin
          errors++;
          $display("FAIL read(%0d,%0d) got=%02h want=%02h", mon_e.r, mon_e.c, bus.character_id, mon_e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic chk_cursor(input string name, input logic [3:0] r, input logic [5:0] c);
    chk(name, {cursor_row, cursor_col}, {r, c});
  endtask

  task automatic send(input logic [7:0] ch);
    int t = 0;
    bus.wr_char  = ch;
    bus.wr_valid = 1'b1;
    while (!bus.wr_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.wr_ready) chk("send_timeout", bus.wr_ready, 1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic count_busy(input string name, input int want);
    int n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, want);
  endtask

  task automatic read(input logic [3:0] r, input logic [5:0] c, input logic [7:0] exp);
    bus.char_row = r;
    bus.char_col = c;
    sb.push_back('{r, c, exp});
    rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  initial begin
    int   c0;
    bus.wr_valid = 1'b0;
    bus.wr_char  = 8'h00;
    bus.char_row = 4'd0;
    bus.char_col = 6'd0;

    // Reset state and power-up clear
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_ready", bus.wr_ready, 0);
    chk("rst_char_id", bus.character_id, 8'h00);
    chk_cursor("rst_cursor", 4'd0, 6'd0);
    reset = 1'b0;
    count_busy("clr_all_cycles", 600);
    chk("ready_after_clr", bus.wr_ready, 1);
    read(4'd0, 6'd0, 8'h00);
    read(4'd14, 6'd39, 8'h00);
    read(4'd7, 6'd20, 8'h00);
    read(4'd15, 6'd0, 8'h00);
    read(4'd0, 6'd40, 8'h00);
    read(4'd14, 6'd63, 8'h00);

    // Plain write, same-cycle read/write, back-to-back writes
    send(8'h21);
    chk_cursor("cursor_after_21", 4'd0, 6'd1);
    read(4'd0, 6'd0, 8'h21);
    bus.char_row = 4'd0;
    bus.char_col = 6'd1;
    sb.push_back('{4'd0, 6'd1, 8'h00});
    rd_issue     = 1'b1;
    bus.wr_char  = 8'h42;
    bus.wr_valid = 1'b1;
    @(negedge clk);
    rd_issue     = 1'b0;
    bus.wr_valid = 1'b0;
    read(4'd0, 6'd1, 8'h42);
    c0 = cyc;
    send(8'h41);
    send(8'h42);
    send(8'h43);
    chk("b2b_cycles", cyc - c0, 3);
    chk_cursor("cursor_after_b2b", 4'd0, 6'd5);
    read(4'd0, 6'd4, 8'h43);

    // Newline, fill a row with wrap, backspace across rows
    send(8'h0A);
    chk_cursor("cursor_nl", 4'd1, 6'd0);
    send(8'h0A);
    for (int i = 0; i < 40; i++) send(8'h30 + 8'(i % 10));
    chk_cursor("cursor_row_wrap", 4'd3, 6'd0);
    send(8'h08);
    chk_cursor("cursor_bs_row", 4'd2, 6'd39);
    read(4'd2, 6'd39, 8'h00);
    read(4'd2, 6'd38, 8'h38);
    read(4'd2, 6'd0, 8'h30);

    // Form feed
    send(8'h0C);
    count_busy("ff_cycles", 600);
    chk_cursor("cursor_ff", 4'd0, 6'd0);
    read(4'd2, 6'd38, 8'h00);
    read(4'd0, 6'd0, 8'h00);

    // Last-row wrap clears row 0 only
    send(8'h5A);
    for (int i = 0; i < 14; i++) send(8'h0A);
    chk_cursor("cursor_row14", 4'd14, 6'd0);
    for (int i = 0; i < 40; i++) send(8'h41 + 8'(i));
    chk_cursor("cursor_wrap_last", 4'd0, 6'd0);
    count_busy("clr_row_cycles", 40);
    for (int i = 0; i < 40; i++) read(4'd0, 6'(i), 8'h00);
    read(4'd14, 6'd0, 8'h41);
    read(4'd14, 6'd20, 8'h55);
    read(4'd14, 6'd39, 8'h68);

    // Backspace at origin does nothing; backspace within a row erases
    send(8'h08);
    chk_cursor("cursor_bs_origin", 4'd0, 6'd0);
    chk("busy_bs_origin", busy, 0);
    read(4'd14, 6'd39, 8'h68);
    send(8'h51);
    read(4'd0, 6'd0, 8'h51);
    send(8'h08);
    chk_cursor("cursor_bs_col", 4'd0, 6'd0);
    read(4'd0, 6'd0, 8'h00);

    // Newline on the last row
    for (int i = 0; i < 14; i++) send(8'h0A);
    send(8'h0A);
    chk_cursor("cursor_nl_last", 4'd0, 6'd0);
    count_busy("nl_clr_row_cycles", 40);
    read(4'd14, 6'd0, 8'h41);

`ifdef TEXT_BUFFER_CURSOR_EN
    begin
      logic [7:0] v [24];
      int         k;
      bus.char_row = 4'd0;
      bus.char_col = 6'd0;
      @(negedge clk);
      for (int i = 0; i < 24; i++) begin
        v[i] = bus.character_id;
        @(negedge clk);
      end
      k = 0;
      for (int i = 1; i < 6; i++) if (k == 0 && v[i] != v[i-1]) k = i;
      chk("blink_value", (v[k] == 8'h7F || v[k] == 8'h00), 1);
      for (int j = 0; j < 16; j++)
        chk("blink_phase", v[k+j], ((j / 4) % 2 == 0) ? v[k] : (v[k] ^ 8'h7F));
    end
`else
    for (int i = 0; i < 8; i++) read(4'd0, 6'd0, 8'h00);
`endif

    // Reset in the middle of a clear; held wr_valid during clear is ignored
    send(8'h0C);
    bus.wr_char  = 8'h4D;
    bus.wr_valid = 1'b1;
    repeat (300) @(negedge clk);
    chk("ready_mid_clear", bus.wr_ready, 0);
    bus.wr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_ready", bus.wr_ready, 0);
    chk("rst2_char_id", bus.character_id, 8'h00);
    count_busy("rst_mid_clear_cycles", 600);
    chk_cursor("cursor_rst2", 4'd0, 6'd0);
    read(4'd15, 6'd3, 8'h00);
    read(4'd14, 6'd0, 8'h00);
    read(4'd0, 6'd0, 8'h00);

    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
